// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised synchronous FIFO.
// Provides the occupancy-counter width helper and the sticky error bundle.
package fifo_pkg;

  // Bits needed to hold an occupancy value from 0 up to and including depth.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Sticky error flags, kept together so they reset and clear as one unit.
  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Circular pointer register for the FIFO storage array.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset, pointer to 0
//   clr  - synchronous clear to 0 (used by flush), wins over inc
//   inc  - advance by one, wrapping from DEPTH-1 back to 0
//   ptr  - current pointer value
module fifo_wrap_ptr
  import fifo_pkg::*;
#(
  parameter int DEPTH = 6,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  // The wrap uses an explicit compare so that non-power-of-2 depths
  // never index past the last entry.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ptr <= '0;
    end else if (inc) begin
      if (ptr == PW'(DEPTH - 1)) begin
        ptr <= '0;
      end else begin
        ptr <= ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO used between pipeline stages.
// Ports:
//   clk, rst        - clock and synchronous active-high reset
//   flush           - clears contents and pointers; error bits are kept
//   clr_err         - clears the sticky overflow/underflow bits
//   wr_en, wr_data  - push request and data
//   rd_en           - pop request
//   rd_data         - read word (FWFT: head of queue; else registered pop data)
//   rd_data_valid   - rd_data holds a valid word
//   full, empty, almost_full, almost_empty, count - occupancy status
//   overflow, underflow - sticky error flags
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 6,
  parameter int AF_THRESH = 5,
  parameter int AE_THRESH = 1,
  parameter bit FWFT      = 1'b1,
  localparam int CW = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             clr_err,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_data_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DEPTH < 2) begin : g_bad_depth
    $error("param_sync_fifo: DEPTH must be at least 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("param_sync_fifo: AF_THRESH must be within 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH >= DEPTH) begin : g_bad_ae
    $error("param_sync_fifo: AE_THRESH must be within 0..DEPTH-1");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  fifo_err_t        err_q;

  logic pop_ok;
  logic push_ok;
  logic pop_acc;
  logic push_acc;
  logic ovf_set;
  logic unf_set;

  // Flags come straight from the registered count so they can never disagree.
  assign count        = count_q;
  assign empty        = (count_q == '0);
  assign full         = (count_q == CW'(DEPTH));
  assign almost_full  = (count_q >= CW'(AF_THRESH));
  assign almost_empty = (count_q <= CW'(AE_THRESH));
  assign overflow     = err_q.overflow;
  assign underflow    = err_q.underflow;

  // A simultaneous pop frees a slot, so a push into a full FIFO is still
  // accepted. An empty FIFO never bypasses a push into a same-cycle pop.
  // Flush overrides both requests and suppresses any error that cycle.
  assign pop_ok   = rd_en & ~empty;
  assign push_ok  = wr_en & (~full | pop_ok);
  assign pop_acc  = pop_ok & ~flush;
  assign push_acc = push_ok & ~flush;
  assign ovf_set  = wr_en & ~push_ok & ~flush;
  assign unf_set  = rd_en & empty & ~flush;

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (push_acc),
    .ptr (wr_ptr)
  );

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (pop_acc),
    .ptr (rd_ptr)
  );

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count_q <= '0;
    end else if (push_acc && !pop_acc) begin
      count_q <= count_q + 1'b1;
    end else if (!push_acc && pop_acc) begin
      count_q <= count_q - 1'b1;
    end
  end

  // A fresh error in the same cycle as clr_err overrides the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= '0;
    end else begin
      if (clr_err) begin
        err_q <= '0;
      end
      if (ovf_set) begin
        err_q.overflow <= 1'b1;
      end
      if (unf_set) begin
        err_q.underflow <= 1'b1;
      end
    end
  end

  if (FWFT) begin : g_fwft
    // Head word is presented directly; forced to zero while empty so the
    // unreset storage never leaks onto the port.
    assign rd_data       = empty ? '0 : mem[rd_ptr];
    assign rd_data_valid = ~empty;
  end else begin : g_reg
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;

    // Registered read: the popped word lands one cycle after the pop edge,
    // valid pulses for that cycle only, and the data holds afterwards.
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else if (flush) begin
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= pop_acc;
        if (pop_acc) begin
          rd_data_q <= mem[rd_ptr];
        end
      end
    end

    assign rd_data       = rd_data_q;
    assign rd_data_valid = rd_valid_q;
  end

endmodule
